// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external combinational adder among NUM_REQ requesters.
// Latency: grant at cycle T, operands on add_a/add_b at T+1, rsp_valid from T+2.
// Backpressure: result held in RESP until rsp_ready; no new grant until the response is consumed.
//
// Ports:
//   clock, reset             rising-edge clock, asynchronous active-high reset
//   req_valid/req_a/req_b    per-requester request and operands (requester i at [i*WIDTH +: WIDTH])
//   req_ready                one-hot grant, combinational, only in IDLE
//   add_a/add_b/add_sum      operands to and sum from the shared adder
//   rsp_valid/rsp_id/rsp_sum/rsp_ovf/rsp_ready   registered response and its consumer handshake
//   busy                     high whenever an operation is in progress
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_sum,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_ovf,
  input  logic                     rsp_ready,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   gnt;
  logic             found;
  logic [WIDTH-1:0] op_a, op_b;

  // Rotating priority: start one past the last winner so a continuously
  // valid requester waits at most NUM_REQ grants.
  always_comb begin : rr_search
    logic [IDW-1:0] idx;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  // Gated by reset so the grant reads as zero while reset is held.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && found && !reset) req_ready[gnt] = 1'b1;
  end

  // The shared adder only sees our operands during ISSUE.
  assign add_a = (state == ISSUE) ? op_a : '0;
  assign add_b = (state == ISSUE) ? op_b : '0;
  assign busy  = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IDW'(NUM_REQ - 1);
      op_a       <= '0;
      op_b       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sum    <= '0;
      rsp_ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (found) begin
            op_a       <= req_a[int'(gnt)*WIDTH +: WIDTH];
            op_b       <= req_b[int'(gnt)*WIDTH +: WIDTH];
            last_grant <= gnt;
          end
        end
        ISSUE: begin
          rsp_sum   <= add_sum;
          // A wrapped unsigned sum is smaller than either operand exactly when it carried out.
          rsp_ovf   <= (add_sum < op_a);
          rsp_id    <= last_grant;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   add_a, add_b, add_sum;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_ovf;
  logic           rsp_ready;
  logic           busy;

  adder_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ovf(rsp_ovf),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  // Shared adder model.
  assign add_sum = add_a + add_b;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: index of the most recently granted requester.
  int model_last;
  logic [W-1:0] ta [N];
  logic [W-1:0] tb [N];

  // Observations captured during one transaction.
  logic [N-1:0] obs_grant;
  int           obs_grant_cyc;
  logic [W-1:0] obs_adda, obs_addb;
  logic [N-1:0] obs_iss_rdy;
  logic         obs_iss_vld;
  logic         obs_vld;
  logic [1:0]   obs_id;
  logic [W-1:0] obs_sum;
  logic         obs_ovf;
  logic         obs_stable, obs_hold_ok;
  logic         obs_idle_vld, obs_idle_busy;

  // Round robin: walk outward from the last winner, first valid wins.
  function automatic int pick(input int last, input logic [N-1:0] v);
    for (int d = 1; d <= N; d++)
      if (v[(last + d) % N]) return (last + d) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] exp_sum(input logic [W-1:0] a, input logic [W-1:0] b);
    int s;
    s = int'(a) + int'(b);
    return W'(s % (1 << W));
  endfunction

  function automatic logic exp_ovf(input logic [W-1:0] a, input logic [W-1:0] b);
    return (int'(a) + int'(b)) >= (1 << W);
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] m;
    m = '0;
    if (g >= 0) m[g] = 1'b1;
    return m;
  endfunction

  task automatic set_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = ta[i];
      req_b[i*W +: W] = tb[i];
    end
  endtask

  // Runs one grant/issue/response sequence starting in IDLE just after a
  // falling edge; holds rsp_ready low for 'hold' RESP cycles.
  task automatic run_op(input logic [N-1:0] mask, input int hold);
    req_valid = mask;
    rsp_ready = (hold == 0);
    #1;
    obs_grant = req_ready; obs_grant_cyc = cyc;
    @(posedge clock); @(negedge clock); #1;
    obs_adda = add_a; obs_addb = add_b; obs_iss_rdy = req_ready; obs_iss_vld = rsp_valid;
    @(posedge clock); @(negedge clock); #1;
    obs_vld = rsp_valid; obs_id = rsp_id; obs_sum = rsp_sum; obs_ovf = rsp_ovf;
    obs_stable = 1'b1; obs_hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); @(negedge clock); #1;
      if (rsp_valid !== 1'b1 || rsp_id !== obs_id || rsp_sum !== obs_sum || rsp_ovf !== obs_ovf)
        obs_stable = 1'b0;
      if (req_ready !== '0 || busy !== 1'b1) obs_hold_ok = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clock); @(negedge clock); #1;
    obs_idle_vld = rsp_valid; obs_idle_busy = busy;
  endtask

  task automatic do_reset();
    @(negedge clock); #1;
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    model_last = N - 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    n_checks++; if (add_a !== '0 || add_b !== '0) begin n_fail++; $display("FAIL reset_add got %h/%h want 0/0", add_a, add_b); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_checks++; if (rsp_id !== '0 || rsp_sum !== '0 || rsp_ovf !== 1'b0)
      begin n_fail++; $display("FAIL reset_rsp got id=%0d sum=%h ovf=%b want 0", rsp_id, rsp_sum, rsp_ovf); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clock);
    reset = 1'b0;
    model_last = N - 1;
  endtask

  task automatic test_basic();
    int g;
    ta[0] = 8'd1; tb[0] = 8'd2; set_ops();
    g = pick(model_last, 4'b0001);
    run_op(4'b0001, 0);
    req_valid = '0;
    model_last = g;
    n_checks++; if (obs_grant !== onehot(g)) begin n_fail++; $display("FAIL basic_grant got %b want %b", obs_grant, onehot(g)); end
    n_checks++; if (obs_adda !== ta[0] || obs_addb !== tb[0])
      begin n_fail++; $display("FAIL basic_issue got %0d/%0d want %0d/%0d", obs_adda, obs_addb, ta[0], tb[0]); end
    n_checks++; if (obs_iss_rdy !== '0 || obs_iss_vld !== 1'b0)
      begin n_fail++; $display("FAIL basic_issue_ctrl got rdy=%b vld=%b want 0/0", obs_iss_rdy, obs_iss_vld); end
    n_checks++; if (obs_vld !== 1'b1 || obs_id !== 2'd0 || obs_sum !== 8'd3 || obs_ovf !== 1'b0)
      begin n_fail++; $display("FAIL basic_rsp got v=%b id=%0d sum=%0d ovf=%b want 1/0/3/0", obs_vld, obs_id, obs_sum, obs_ovf); end
    n_checks++; if (obs_idle_vld !== 1'b0 || obs_idle_busy !== 1'b0)
      begin n_fail++; $display("FAIL basic_idle got vld=%b busy=%b want 0/0", obs_idle_vld, obs_idle_busy); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] av [2];
    logic [W-1:0] bv [2];
    av[0] = 8'd200; bv[0] = 8'd100;
    av[1] = 8'd255; bv[1] = 8'd0;
    for (int i = 0; i < 2; i++) begin
      ta[1] = av[i]; tb[1] = bv[i]; set_ops();
      run_op(4'b0010, 0);
      model_last = 1;
      n_checks++; if (obs_sum !== exp_sum(av[i], bv[i]) || obs_ovf !== exp_ovf(av[i], bv[i]) || obs_id !== 2'd1)
        begin n_fail++; $display("FAIL ovf_%0d got id=%0d sum=%0d ovf=%b want 1/%0d/%b", i, obs_id, obs_sum, obs_ovf,
                                 exp_sum(av[i], bv[i]), exp_ovf(av[i], bv[i])); end
    end
    req_valid = '0;
  endtask

  task automatic test_back_to_back();
    int g, prev_cyc;
    do_reset();
    @(negedge clock);
    for (int i = 0; i < N; i++) begin ta[i] = W'(10 * i + 3); tb[i] = W'(250 - i); end
    set_ops();
    prev_cyc = -1;
    for (int n = 0; n < 5; n++) begin
      g = pick(model_last, 4'b1111);
      run_op(4'b1111, 0);
      n_checks++; if (obs_grant !== onehot(g) || obs_id !== 2'(g) || obs_sum !== exp_sum(ta[g], tb[g]) || obs_ovf !== exp_ovf(ta[g], tb[g]))
        begin n_fail++; $display("FAIL b2b_%0d got grant=%b id=%0d sum=%0d ovf=%b want grant=%b", n, obs_grant, obs_id, obs_sum, obs_ovf, onehot(g)); end
      if (prev_cyc >= 0) begin
        n_checks++; if (obs_grant_cyc - prev_cyc !== 3)
          begin n_fail++; $display("FAIL b2b_spacing_%0d got %0d cycles want 3", n, obs_grant_cyc - prev_cyc); end
      end
      prev_cyc = obs_grant_cyc;
      model_last = g;
    end
    req_valid = '0;
  endtask

  task automatic test_hold();
    int g;
    ta[2] = 8'h81; tb[2] = 8'h90; set_ops();
    g = pick(model_last, 4'b0100);
    run_op(4'b0100, 5);
    model_last = g;
    n_checks++; if (obs_stable !== 1'b1) begin n_fail++; $display("FAIL hold_stable got %b want 1", obs_stable); end
    n_checks++; if (obs_hold_ok !== 1'b1) begin n_fail++; $display("FAIL hold_ready_busy got %b want 1", obs_hold_ok); end
    n_checks++; if (obs_sum !== exp_sum(ta[2], tb[2]) || obs_ovf !== exp_ovf(ta[2], tb[2]))
      begin n_fail++; $display("FAIL hold_rsp got sum=%h ovf=%b", obs_sum, obs_ovf); end
    n_checks++; if (obs_idle_busy !== 1'b0 || obs_idle_vld !== 1'b0)
      begin n_fail++; $display("FAIL hold_idle got busy=%b vld=%b want 0/0", obs_idle_busy, obs_idle_vld); end
    // Valid still held: the next grant is visible in this first IDLE cycle.
    n_checks++; if (req_ready !== onehot(pick(model_last, 4'b0100)))
      begin n_fail++; $display("FAIL hold_next_grant got %b want %b", req_ready, onehot(pick(model_last, 4'b0100))); end
    req_valid = '0;
  endtask

  task automatic test_last_grant2();
    int g;
    ta[0] = 8'd7; tb[0] = 8'd8; ta[2] = 8'd9; tb[2] = 8'd250; set_ops();
    run_op(4'b0100, 0);
    model_last = 2;
    for (int n = 0; n < 2; n++) begin
      g = pick(model_last, 4'b0101);
      run_op(4'b0101, 0);
      n_checks++; if (obs_grant !== onehot(g) || obs_id !== 2'(g))
        begin n_fail++; $display("FAIL lg2_%0d got grant=%b id=%0d want grant=%b", n, obs_grant, obs_id, onehot(g)); end
      model_last = g;
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    int g, hold;
    for (int n = 0; n < 30; n++) begin
      mask = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin ta[i] = W'($urandom); tb[i] = W'($urandom); end
      set_ops();
      hold = $urandom_range(0, 2);
      if (mask == '0) begin
        req_valid = '0; #1;
        n_checks++; if (req_ready !== '0 || busy !== 1'b0)
          begin n_fail++; $display("FAIL rnd_idle_%0d got rdy=%b busy=%b want 0/0", n, req_ready, busy); end
        @(negedge clock);
      end else begin
        g = pick(model_last, mask);
        run_op(mask, hold);
        n_checks++; if (obs_grant !== onehot(g))
          begin n_fail++; $display("FAIL rnd_grant_%0d got %b want %b", n, obs_grant, onehot(g)); end
        n_checks++; if (obs_adda !== ta[g] || obs_addb !== tb[g])
          begin n_fail++; $display("FAIL rnd_issue_%0d got %h/%h want %h/%h", n, obs_adda, obs_addb, ta[g], tb[g]); end
        n_checks++; if (obs_vld !== 1'b1 || obs_id !== 2'(g) || obs_sum !== exp_sum(ta[g], tb[g]) || obs_ovf !== exp_ovf(ta[g], tb[g]))
          begin n_fail++; $display("FAIL rnd_rsp_%0d got v=%b id=%0d sum=%h ovf=%b want 1/%0d/%h/%b", n, obs_vld, obs_id,
                                   obs_sum, obs_ovf, g, exp_sum(ta[g], tb[g]), exp_ovf(ta[g], tb[g])); end
        n_checks++; if (obs_stable !== 1'b1 || obs_hold_ok !== 1'b1 || obs_idle_vld !== 1'b0)
          begin n_fail++; $display("FAIL rnd_hold_%0d got stable=%b ok=%b idle_vld=%b", n, obs_stable, obs_hold_ok, obs_idle_vld); end
        model_last = g;
        req_valid = '0;
      end
    end
  endtask

  task automatic test_reset_mid();
    ta[3] = 8'h5A; tb[3] = 8'hC3; ta[0] = 8'h11; tb[0] = 8'h22; set_ops();
    @(negedge clock);
    req_valid = 4'b1000; rsp_ready = 1'b0;
    @(posedge clock); @(negedge clock); #1;
    n_checks++; if (add_a !== ta[3] || busy !== 1'b1)
      begin n_fail++; $display("FAIL rmid_issue got add_a=%h busy=%b want %h/1", add_a, busy, ta[3]); end
    reset = 1'b1; #1;
    n_checks++; if (add_a !== '0 || add_b !== '0 || busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== '0)
      begin n_fail++; $display("FAIL rmid_reset got add=%h/%h busy=%b vld=%b rdy=%b want all 0", add_a, add_b, busy, rsp_valid, req_ready); end
    @(negedge clock);
    reset = 1'b0; req_valid = 4'b1111; #1;
    n_checks++; if (req_ready !== 4'b0001)
      begin n_fail++; $display("FAIL rmid_first_grant got %b want 0001", req_ready); end
    // Second case: reset while a response is being held.
    @(posedge clock); @(negedge clock); @(posedge clock); @(negedge clock); #1;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_sum !== exp_sum(ta[0], tb[0]))
      begin n_fail++; $display("FAIL rmid_resp got vld=%b sum=%h want 1/%h", rsp_valid, rsp_sum, exp_sum(ta[0], tb[0])); end
    reset = 1'b1; #1;
    n_checks++; if (rsp_valid !== 1'b0 || rsp_sum !== '0 || rsp_id !== '0)
      begin n_fail++; $display("FAIL rmid_resp_reset got vld=%b sum=%h id=%0d want 0", rsp_valid, rsp_sum, rsp_id); end
    @(negedge clock);
    reset = 1'b0; #1;
    n_checks++; if (req_ready !== 4'b0001)
      begin n_fail++; $display("FAIL rmid_regrant got %b want 0001", req_ready); end
    req_valid = '0;
    model_last = N - 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_hold();
    test_last_grant2();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d, want test completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
